writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/rv32i_pkg.sv | 6 +
 rtl/wb_fifo.sv | 37 +++
 rtl/writeback_unit.sv | 64 ++++++
 tb/tb_writeback_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: register-file constants shared across the pipeline
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer holding load responses until the write port is free
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end
  always_ff @(posedge clk) if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: load scoreboard, ALU/load writeback arbitration and registered write port
module writeback_unit
  import rv32i_pkg::REG_ADDR_W, rv32i_pkg::X0;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN = rv32i_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic                  ld_resp_valid,
  input  logic [REG_ADDR_W-1:0] ld_resp_rd,
  input  logic [XLEN-1:0]       ld_resp_data,
  output logic                  ld_resp_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_wdata,
  output logic                  stall,
  output logic [31:0]           pending_mask
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] pend, set_mask, clr_mask;
  logic [REG_ADDR_W+XLEN-1:0] head;
  logic [REG_ADDR_W-1:0] head_rd, sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [CW-1:0] count;
  logic full, empty, alu_acc, ld_acc, pop;
  wb_fifo #(.DEPTH(FIFO_DEPTH), .W(REG_ADDR_W + XLEN)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(ld_resp_valid && ld_resp_ready), .pop(pop),
    .din({ld_resp_rd, ld_resp_data}), .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign head_rd = head[XLEN +: REG_ADDR_W];
  assign ld_resp_ready = count != CW'(FIFO_DEPTH);
  // pend[0] is never set, so x0 sources/destinations never stall
  assign stall = alu_valid && (pend[rs1_addr] || pend[rs2_addr] || pend[alu_rd] ||
                               (ld_issue && pend[ld_issue_rd]) || full);
  assign alu_acc = alu_valid && !stall;
  assign ld_acc = ld_issue && !stall;
  assign pop = !alu_acc && !empty;
  assign sel_rd = alu_acc ? alu_rd : pop ? head_rd : X0;
  assign sel_data = alu_acc ? alu_data : pop ? head[XLEN-1:0] : '0;
  assign set_mask = ld_acc ? 32'd1 << ld_issue_rd : '0;
  assign clr_mask = pop ? 32'd1 << head_rd : '0;
  assign pending_mask = pend;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_wdata <= '0;
      pend <= '0;
    end else begin
      wb_we <= sel_rd != X0;
      wb_rd <= sel_rd;
      wb_wdata <= sel_data;
      pend <= ((pend & ~clr_mask) | set_mask) & ~32'd1;
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: queue-based reference model plus directed writeback scenarios
module tb_writeback_unit;
  localparam int DEPTH = 2;
  typedef struct { logic [4:0] rd; logic [31:0] data; } resp_t;
  logic clk = 0, rst_n = 0;
  logic alu_valid, ld_issue, ld_resp_valid, ld_resp_ready, wb_we, stall;
  logic [4:0] alu_rd, ld_issue_rd, ld_resp_rd, rs1_addr, rs2_addr, wb_rd;
  logic [31:0] alu_data, ld_resp_data, wb_wdata, pending_mask;
  int n_chk = 0, n_fail = 0;
  resp_t q[$];
  resp_t hd;
  logic [31:0] pend_m = 0, exp_data = 0;
  logic [4:0] exp_rd = 0;
  bit exp_we = 0, armed = 0, full_now, st_now;

  writeback_unit #(.FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_resp_valid(ld_resp_valid),
    .ld_resp_rd(ld_resp_rd), .ld_resp_data(ld_resp_data), .ld_resp_ready(ld_resp_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_wdata(wb_wdata), .stall(stall), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    return alu_valid && ((rs1_addr != 0 && pend_m[rs1_addr]) || (rs2_addr != 0 && pend_m[rs2_addr]) ||
                         (alu_rd != 0 && pend_m[alu_rd]) || (ld_issue && pend_m[ld_issue_rd]) ||
                         q.size() == DEPTH);
  endfunction

  task automatic drain();
    hd = q.pop_front();
    exp_we = hd.rd != 0;
    exp_rd = hd.rd;
    exp_data = hd.data;
    pend_m[hd.rd] = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      pend_m = 0;
      exp_we = 0;
      armed = 1;
    end else begin
      full_now = q.size() == DEPTH;
      st_now = m_stall();
      exp_we = 0;
      if (full_now) drain();
      else if (alu_valid && !st_now) begin
        exp_we = alu_rd != 0;
        exp_rd = alu_rd;
        exp_data = alu_data;
      end else if (q.size() != 0) drain();
      if (ld_issue && !st_now && ld_issue_rd != 0) pend_m[ld_issue_rd] = 1'b1;
      if (ld_resp_valid && !full_now) q.push_back('{rd: ld_resp_rd, data: ld_resp_data});
    end
  end

  always @(negedge clk) if (armed) begin
    chk("model stall", stall, m_stall());
    chk("model ld_resp_ready", ld_resp_ready, q.size() != DEPTH);
    chk("model pending_mask", pending_mask, pend_m);
    chk("model wb_we", wb_we, exp_we);
    if (exp_we) begin
      chk("model wb_rd", wb_rd, exp_rd);
      chk("model wb_wdata", wb_wdata, exp_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0; rs1_addr = 0; rs2_addr = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_resp_valid = 0; ld_resp_rd = 0; ld_resp_data = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    alu_valid = 1; alu_rd = rd; alu_data = d; rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic issue(input logic [4:0] rd);
    ld_issue = 1; ld_issue_rd = rd;
  endtask

  task automatic resp(input logic [4:0] rd, input logic [31:0] d);
    ld_resp_valid = 1; ld_resp_rd = rd; ld_resp_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    chk("rst wb_we", wb_we, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst wb_wdata", wb_wdata, 0);
    chk("rst pending", pending_mask, 0);
    chk("rst ready", ld_resp_ready, 1);
    chk("rst stall", stall, 0);
    rst_n = 1;
    alu(5, 32'hDEADBEEF, 0, 0); #1;
    chk("alu stall", stall, 0);
    tick(); idle();
    chk("alu wb_we", wb_we, 1);
    chk("alu wb_rd", wb_rd, 5);
    chk("alu wb_wdata", wb_wdata, 32'hDEADBEEF);
    issue(7); tick(); idle();
    chk("raw pending", pending_mask, 32'h80);
    alu(8, 32'h1, 7, 0); #1;
    chk("raw stall", stall, 1);
    tick(); tick();
    resp(7, 32'h12345678); tick(); ld_resp_valid = 0; #1;
    chk("raw stall held", stall, 1);
    tick();
    chk("raw wb_we", wb_we, 1);
    chk("raw wb_rd", wb_rd, 7);
    chk("raw wb_wdata", wb_wdata, 32'h12345678);
    chk("raw pending clr", pending_mask, 0);
    chk("raw stall drop", stall, 0);
    tick(); idle();
    chk("raw alu wb_rd", wb_rd, 8);
    chk("raw alu wb_wdata", wb_wdata, 1);
    issue(10); tick(); issue(11); tick(); idle();
    alu(12, 32'hA12, 1, 2); resp(10, 32'h1010); tick();
    chk("fill wb_rd 12", wb_rd, 12);
    alu(13, 32'hA13, 1, 2); resp(11, 32'h1111); tick();
    chk("fill wb_rd 13", wb_rd, 13);
    ld_resp_valid = 0; alu(14, 32'hA14, 1, 2); #1;
    chk("full ready", ld_resp_ready, 0);
    chk("full stall", stall, 1);
    tick();
    chk("drain1 wb_rd", wb_rd, 10);
    chk("drain1 wb_wdata", wb_wdata, 32'h1010);
    tick();
    chk("held alu wb_rd", wb_rd, 14);
    idle(); tick();
    chk("drain2 wb_rd", wb_rd, 11);
    chk("drain2 wb_wdata", wb_wdata, 32'h1111);
    chk("drain pending", pending_mask, 0);
    issue(3); tick(); idle();
    resp(3, 32'h33); tick(); idle();
    issue(3); tick(); idle();
    chk("setclr wb_rd", wb_rd, 3);
    chk("setclr pending", pending_mask, 32'h8);
    resp(3, 32'h34); tick(); idle(); tick();
    chk("setclr final pending", pending_mask, 0);
    alu(0, 32'h55, 0, 0); tick(); idle();
    chk("x0 alu wb_we", wb_we, 0);
    alu(20, 32'h20, 0, 0); resp(0, 32'h66); tick();
    alu(21, 32'h21, 0, 0); resp(9, 32'h99); tick(); idle(); #1;
    chk("x0 full ready", ld_resp_ready, 0);
    tick();
    chk("x0 load wb_we", wb_we, 0);
    chk("x0 load ready", ld_resp_ready, 1);
    tick();
    chk("nonpend wb_rd", wb_rd, 9);
    chk("nonpend wb_wdata", wb_wdata, 32'h99);
    issue(21); tick(); issue(22); tick(); idle();
    alu(23, 32'h23, 0, 0); resp(21, 32'h2121); tick();
    alu(24, 32'h24, 0, 0); resp(22, 32'h2222); tick(); idle(); #1;
    chk("pre-rst ready", ld_resp_ready, 0);
    chk("pre-rst pending", pending_mask, 32'h0060_0000);
    rst_n = 0; tick();
    chk("mid-rst wb_we", wb_we, 0);
    chk("mid-rst wb_rd", wb_rd, 0);
    chk("mid-rst wb_wdata", wb_wdata, 0);
    chk("mid-rst pending", pending_mask, 0);
    chk("mid-rst ready", ld_resp_ready, 1);
    rst_n = 1; tick();
    chk("post-rst wb_we 1", wb_we, 0);
    tick();
    chk("post-rst wb_we 2", wb_we, 0);
    chk("post-rst ready", ld_resp_ready, 1);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
